// File: rtl/noc_pkt_pkg.sv
//------------------------------------------------------------------------------
// Module  : noc_pkt_pkg
// Purpose : Shared mesh packet field map, hop limit, injector FSM states and
//           a per-axis direction/distance helper.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package noc_pkt_pkg;

    localparam int DIR_X       = 62;
    localparam int DIR_Y       = 61;
    localparam int SEQ_MSB     = 60;
    localparam int SEQ_LSB     = 56;
    localparam int HOP_X_MSB   = 55;
    localparam int HOP_X_LSB   = 52;
    localparam int HOP_Y_MSB   = 51;
    localparam int HOP_Y_LSB   = 48;
    localparam int SRC_X_MSB   = 47;
    localparam int SRC_X_LSB   = 40;
    localparam int SRC_Y_MSB   = 39;
    localparam int SRC_Y_LSB   = 32;
    localparam int PAYLOAD_MSB = 31;
    localparam int PAYLOAD_LSB = 0;

    // Largest hop count a 4-bit hop field can carry.
    localparam int MAX_HOP = 15;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } inj_state_t;

    // Returns {dir, |dst - src|}; dir=1 when dst >= src (9-bit unsigned compare).
    function automatic logic [8:0] axis_diff(input logic [7:0] dst, input logic [7:0] src);
        logic [8:0] d;
        d = {1'b0, dst} - {1'b0, src};
        if (d[8]) begin
            return {1'b0, src - dst};
        end
        return {1'b1, d[7:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/inj_fifo.sv
//------------------------------------------------------------------------------
// Module  : inj_fifo
// Purpose : Synchronous packet FIFO with occupancy count. Exposes the head
//           entry and the entry behind it so the owner can register the next
//           head in the same cycle it pops.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inj_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head_data,
    output logic [WIDTH-1:0]         next_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;

    // Pointers are power-of-two wide, so increments wrap at DEPTH for free.
    assign rd_ptr_nxt = rd_ptr + 1'b1;
    assign head_data  = mem[rd_ptr];
    assign next_data  = mem[rd_ptr_nxt];
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);

    // Storage array: written on push only, contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; push+pop together leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pe_packet_injector.sv
//------------------------------------------------------------------------------
// Module  : pe_packet_injector
// Purpose : Builds source-routed mesh headers from PE write requests, drops
//           requests whose hop distance exceeds the field range, buffers the
//           rest and injects them into the local router with send/ready.
// Config  : INJ_SEQ_EN - stamp a wrapping 5-bit sequence number per packet.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pe_packet_injector
    import noc_pkt_pkg::*;
#(
    parameter int          DATA_WIDTH      = 64,
    parameter logic [15:0] CURRENT_ADDRESS = 16'h0000,
    parameter int          FIFO_DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  peWrEn,
    input  logic [15:0]           peDest,
    input  logic [31:0]           pePayload,
    output logic                  peReady,
    output logic                  peErr,
    output logic                  outSend,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] outData,
    output logic [7:0]            dropCount
);

    localparam int         CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] SRC_XA = CURRENT_ADDRESS[15:8];
    localparam logic [7:0] SRC_YA = CURRENT_ADDRESS[7:0];

    logic [8:0]            axis_x;
    logic [8:0]            axis_y;
    logic                  range_err;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [4:0]            seq;
    logic [DATA_WIDTH-1:0] packet;
    logic [DATA_WIDTH-1:0] head_data;
    logic [DATA_WIDTH-1:0] next_data;
    logic [CNT_W-1:0]      count;
    logic                  fifo_full;
    logic                  fifo_empty;
    inj_state_t            state;

    assign axis_x    = axis_diff(peDest[15:8], SRC_XA);
    assign axis_y    = axis_diff(peDest[7:0], SRC_YA);
    assign range_err = (axis_x[7:0] > 8'(MAX_HOP)) || (axis_y[7:0] > 8'(MAX_HOP));

    // Readiness reflects occupancy before any pop this cycle, so a full
    // buffer never takes a push even while it is draining.
    assign peReady = ~fifo_full;
    assign accept  = peWrEn & peReady;
    assign push    = accept & ~range_err;
    assign pop     = outSend & outReady;

`ifdef INJ_SEQ_EN
    logic [4:0] seq_cnt;

    // Sequence number advances only for packets that enter the buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_cnt <= '0;
        end else if (push) begin
            seq_cnt <= seq_cnt + 5'd1;
        end
    end

    assign seq = seq_cnt;
`else
    assign seq = 5'd0;
`endif

    // Header encoder: pack direction, hops, source and payload into the field map.
    always_comb begin
        packet                          = '0;
        packet[DIR_X]                   = axis_x[8];
        packet[DIR_Y]                   = axis_y[8];
        packet[SEQ_MSB:SEQ_LSB]         = seq;
        packet[HOP_X_MSB:HOP_X_LSB]     = axis_x[3:0];
        packet[HOP_Y_MSB:HOP_Y_LSB]     = axis_y[3:0];
        packet[SRC_X_MSB:SRC_X_LSB]     = SRC_XA;
        packet[SRC_Y_MSB:SRC_Y_LSB]     = SRC_YA;
        packet[PAYLOAD_MSB:PAYLOAD_LSB] = pePayload;
    end

    inj_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (packet),
        .pop       (pop),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_data),
        .next_data (next_data)
    );

    // Drop reporting: one-cycle error pulse and saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peErr     <= 1'b0;
            dropCount <= '0;
        end else begin
            peErr <= accept & range_err;
            if (accept && range_err && (dropCount != 8'hFF)) begin
                dropCount <= dropCount + 8'd1;
            end
        end
    end

    // Output FSM: registers the buffer head onto outData, reloading the
    // following entry (or the packet being pushed) on the popping edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            outSend <= 1'b0;
            outData <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state   <= ST_SEND;
                        outSend <= 1'b1;
                        outData <= head_data;
                    end
                end
                ST_SEND: begin
                    if (pop) begin
                        if (count > CNT_W'(1)) begin
                            outData <= next_data;
                        end else if (push) begin
                            outData <= packet;
                        end else begin
                            state   <= ST_IDLE;
                            outSend <= 1'b0;
                            outData <= '0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    outSend <= 1'b0;
                    outData <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pe_packet_injector.sv
//------------------------------------------------------------------------------
// Module  : tb_pe_packet_injector
// Purpose : Self-checking bench for pe_packet_injector (node 03/03, depth 4).
//           A queue-level model predicts every output each cycle; literal
//           expectations pin the model at key points.
// Config  : INJ_SEQ_EN - model stamps sequence numbers when defined.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pe_packet_injector;

    localparam int          DEPTH = 4;
    localparam logic [15:0] SRC   = 16'h0303;
    // Literal expectations ignore the sequence field so they hold in both builds.
    localparam logic [63:0] NOSEQ = 64'hE0FF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        peWrEn;
    logic [15:0] peDest;
    logic [31:0] pePayload;
    logic        peReady;
    logic        peErr;
    logic        outSend;
    logic        outReady;
    logic [63:0] outData;
    logic [7:0]  dropCount;

    int errors;
    int checks;
    bit checking;

    pe_packet_injector #(
        .DATA_WIDTH      (64),
        .CURRENT_ADDRESS (SRC),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .peWrEn    (peWrEn),
        .peDest    (peDest),
        .pePayload (pePayload),
        .peReady   (peReady),
        .peErr     (peErr),
        .outSend   (outSend),
        .outReady  (outReady),
        .outData   (outData),
        .dropCount (dropCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding from the protocol rules: returns {drop, packet}.
    function automatic logic [64:0] model_pkt(input logic [15:0] dest, input logic [31:0] pay,
                                              input int seq);
        int          dx;
        int          dy;
        int          hx;
        int          hy;
        logic [63:0] p;
        logic [4:0]  s;
        bit          bad;
        dx  = int'(dest[15:8]) - int'(SRC[15:8]);
        dy  = int'(dest[7:0]) - int'(SRC[7:0]);
        hx  = (dx < 0) ? -dx : dx;
        hy  = (dy < 0) ? -dy : dy;
        bad = (hx > 15) || (hy > 15);
        s   = 5'(seq);
        p   = 64'd0;
        p[62]    = (dx >= 0);
        p[61]    = (dy >= 0);
        p[60:56] = s;
        p[55:52] = 4'(hx);
        p[51:48] = 4'(hy);
        p[47:32] = SRC;
        p[31:0]  = pay;
        return {bad, p};
    endfunction

    // Behavioural model state: packet queue plus visible-output flag.
    logic [63:0] mq [$];
    bit          m_send;
    bit          m_err;
    int          m_drop;
    int          m_seq;
    int          n_before;
    bit          m_acc;
    bit          m_pop;
    logic [64:0] m_enc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_send = 1'b0;
            m_err  = 1'b0;
            m_drop = 0;
            m_seq  = 0;
        end else begin
            n_before = mq.size();
            m_acc    = peWrEn && (n_before < DEPTH);
            m_pop    = m_send && outReady;
`ifdef INJ_SEQ_EN
            m_enc    = model_pkt(peDest, pePayload, m_seq);
`else
            m_enc    = model_pkt(peDest, pePayload, 0);
`endif
            if (m_pop) begin
                void'(mq.pop_front());
            end
            if (m_acc && !m_enc[64]) begin
                mq.push_back(m_enc[63:0]);
                m_seq = (m_seq + 1) % 32;
            end
            m_err = m_acc && m_enc[64];
            if (m_err && m_drop < 255) begin
                m_drop++;
            end
            // A packet written into an empty buffer shows one cycle after its
            // write edge; once sending, the next entry follows back to back.
            if (m_send) begin
                m_send = (mq.size() > 0);
            end else begin
                m_send = (n_before > 0);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check("outSend", 64'(outSend), 64'(m_send));
            if (m_send && mq.size() > 0) begin
                check("outData", outData, mq[0]);
            end else begin
                check("outData", outData, 64'd0);
            end
            check("peReady", 64'(peReady), 64'(mq.size() < DEPTH));
            check("peErr", 64'(peErr), 64'(m_err));
            check("dropCount", 64'(dropCount), 64'(m_drop));
        end
    end

    task automatic drive(input bit we, input logic [15:0] d, input logic [31:0] p);
        peWrEn    = we;
        peDest    = d;
        pePayload = p;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [15:0] vec_dest [7];
    logic [15:0] stall_pat;

    initial begin
        errors    = 0;
        checks    = 0;
        checking  = 1'b0;
        reset     = 1'b1;
        outReady  = 1'b1;
        drive(1'b0, 16'h0000, 32'h0);
        vec_dest  = '{16'h0000, 16'h1203, 16'h0312, 16'h1303, 16'h0313, 16'hFF00, 16'h0203};
        stall_pat = 16'b1011_0010_1101_0110;

        cyc(2);
        checking = 1'b1;
        check("rst_outSend", 64'(outSend), 64'd0);
        check("rst_outData", outData, 64'd0);
        check("rst_dropCount", 64'(dropCount), 64'd0);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        check("rst_peReady", 64'(peReady), 64'd1);

        // Basic east/south packet: dx=+2, dy=-2.
        drive(1'b1, 16'h0501, 32'hCAFE0001);
        cyc(1);
        drive(1'b0, 16'h0000, 32'h0);
        check("lat_no_bypass", 64'(outSend), 64'd0);
        cyc(1);
        check("basic_send", 64'(outSend), 64'd1);
        check("basic_data", outData & NOSEQ, 64'h4022_0303_CAFE_0001);
        cyc(1);
        check("basic_one_cycle", 64'(outSend), 64'd0);

        // Local delivery: dest equals source.
        drive(1'b1, 16'h0303, 32'h11112222);
        cyc(1);
        drive(1'b0, 16'h0000, 32'h0);
        cyc(1);
        check("local_data", outData & NOSEQ, 64'h6000_0303_1111_2222);
        cyc(1);

        // Out of range in x (dx=17): dropped, error pulse, nothing sent.
        drive(1'b1, 16'h1403, 32'hDEADBEEF);
        cyc(1);
        drive(1'b0, 16'h0000, 32'h0);
        check("drop_err", 64'(peErr), 64'd1);
        check("drop_cnt", 64'(dropCount), 64'd1);
        cyc(1);
        check("drop_err_pulse", 64'(peErr), 64'd0);
        check("drop_nosend", 64'(outSend), 64'd0);
        cyc(1);

        // Westward/northward and hop-range boundary vectors.
        drive(1'b1, 16'h0000, 32'h00000BAD);
        cyc(1);
        drive(1'b0, 16'h0000, 32'h0);
        cyc(1);
        check("neg_data", outData & NOSEQ, 64'h0033_0303_0000_0BAD);
        cyc(1);
        foreach (vec_dest[i]) begin
            drive(1'b1, vec_dest[i], 32'h5000_0000 + 32'(i));
            cyc(1);
            drive(1'b0, 16'h0000, 32'h0);
            cyc(2);
        end

        // Stall: five writes into a depth-4 buffer, fifth must be ignored.
        outReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h0404 + 16'(i), 32'hA000_0000 + 32'(i));
            cyc(1);
            if (i == 3) begin
                check("full_peReady", 64'(peReady), 64'd0);
            end
        end
        drive(1'b0, 16'h0000, 32'h0);
        cyc(3);
        check("stall_head", 64'(outData[31:0]), 64'hA000_0000);
        outReady = 1'b1;
        cyc(6);

        // Refill, then stream writes every cycle with the router always ready.
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h0202, 32'hB000_0000 + 32'(i));
            cyc(1);
        end
        outReady = 1'b1;
        for (int i = 4; i < 14; i++) begin
            drive(1'b1, 16'h0202, 32'hB000_0000 + 32'(i));
            cyc(1);
        end
        drive(1'b0, 16'h0000, 32'h0);
        cyc(6);

        // Asynchronous reset in the middle of a stall with 3 packets buffered.
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0303, 32'hC000_0000 + 32'(i));
            cyc(1);
        end
        drive(1'b0, 16'h0000, 32'h0);
        cyc(1);
        check("pre_rst_send", 64'(outSend), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_send", 64'(outSend), 64'd0);
        check("async_rst_data", outData, 64'd0);
        cyc(1);
        reset    = 1'b0;
        outReady = 1'b1;
        cyc(1);
        check("post_rst_ready", 64'(peReady), 64'd1);
        cyc(2);
        check("post_rst_empty", 64'(outSend), 64'd0);

        // 34 requests back to back with one drop among them (sequence wrap).
        for (int i = 0; i < 34; i++) begin
            if (i == 10) begin
                drive(1'b1, 16'h1403, 32'hEEEE_EEEE);
            end else begin
                drive(1'b1, 16'h0505, 32'hD000_0000 + 32'(i));
            end
            cyc(1);
        end
        drive(1'b0, 16'h0000, 32'h0);
        cyc(4);

        // Irregular router backpressure with continuous writes.
        for (int i = 0; i < 16; i++) begin
            outReady = stall_pat[i];
            drive(1'b1, (i % 5 == 4) ? 16'h0013 : 16'h0106, 32'hF000_0000 + 32'(i));
            cyc(1);
        end
        drive(1'b0, 16'h0000, 32'h0);
        outReady = 1'b1;
        cyc(8);

        // Drop counter saturation.
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 16'h1403, 32'(i));
            cyc(1);
        end
        drive(1'b0, 16'h0000, 32'h0);
        cyc(1);
        check("drop_saturate", 64'(dropCount), 64'd255);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
